fd_image_loader: RTL and testbench

- Write side of the FAST9 pixel SRAM. The detector's controller only reads this SRAM; this block fills it.
- Accepts a raster-order 8-bit pixel stream over a valid/ready handshake and writes each pixel to the 15-bit SRAM address space.
- Signals when a full frame is resident so corner detection can start.
- Owns the SRAM port (address, data, wren) while loading; the detector owns it otherwise.

---
 rtl/fd_image_loader_if.sv | 33 +++
 rtl/fd_image_loader.sv | 186 ++++++++++++++++++
 tb/tb_fd_image_loader.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/fd_image_loader_if.sv
// rtl/fd_image_loader_if.sv - pixel stream and SRAM write port bundle for fd_image_loader
//
// Purpose: groups the raster pixel stream and the SRAM write port that the
// image loader sits between.
// Signals:
//   pixValid  source -> loader   pixData/pixSof valid this cycle
//   pixData   source -> loader   8-bit pixel intensity
//   pixSof    source -> loader   first pixel of a frame (qualified by pixValid)
//   pixReady  loader -> source   loader accepts a pixel this cycle
//   sramAddr  loader -> SRAM     15-bit write address
//   sramData  loader -> SRAM     8-bit write data
//   wren      loader -> SRAM     write enable
// Modports: master = pixel source / SRAM side, slave = the loader.

interface fd_image_loader_if;
  logic        pixValid;
  logic [7:0]  pixData;
  logic        pixSof;
  logic        pixReady;
  logic [14:0] sramAddr;
  logic [7:0]  sramData;
  logic        wren;

  modport master (
    output pixValid, pixData, pixSof,
    input  pixReady, sramAddr, sramData, wren
  );

  modport slave (
    input  pixValid, pixData, pixSof,
    output pixReady, sramAddr, sramData, wren
  );
endinterface

// File: rtl/fd_image_loader.sv
// rtl/fd_image_loader.sv - fills the FAST9 pixel SRAM from a raster pixel stream
//
// Purpose: accepts a raster-order 8-bit pixel stream and writes each pixel into
// the SRAM at BASE_ADDR + row*IMG_W + col, one cycle after acceptance. Reports
// a fully resident frame with a one-cycle loadDone pulse.
// Ports:
//   clock     system clock, rising edge
//   nReset    asynchronous active-low reset
//   start     single-cycle pulse, arms a frame load (only honoured when idle)
//   bus       slave side of fd_image_loader_if (pixel stream in, SRAM write out)
//   busy      load in progress; detector must keep off the SRAM
//   loadDone  one-cycle pulse, full frame written
//   frameErr  sticky; SOF missing on first beat or SOF arriving mid-frame

module fd_image_loader #(
  parameter int IMG_W     = 160,
  parameter int IMG_H     = 120,
  parameter int BASE_ADDR = 0
) (
  input  logic                clock,
  input  logic                nReset,
  input  logic                start,
  fd_image_loader_if.slave    bus,
  output logic                busy,
  output logic                loadDone,
  output logic                frameErr
);

  // LAST_S covers the cycle in which the final pixel is being written: the
  // stream is already stalled but the SRAM is still ours, so busy stays high.
  typedef enum logic [2:0] {
    IDLE,
    WAIT_SOF,
    LOAD,
    LAST_S,
    DONE_S
  } state_t;

  localparam logic [7:0]  COL_MAX = 8'(IMG_W - 1);
  localparam logic [7:0]  ROW_MAX = 8'(IMG_H - 1);
  localparam logic [14:0] BASE    = 15'(BASE_ADDR);

  state_t      state_q, state_d;
  logic [7:0]  col_q, col_d;
  logic [7:0]  row_q, row_d;
  logic [14:0] addr_q, addr_d;          // address of the next pixel to accept
  logic [14:0] sram_addr_q, sram_addr_d;
  logic [7:0]  sram_data_q, sram_data_d;
  logic        wren_q, wren_d;
  logic        busy_q, busy_d;
  logic        load_done_q, load_done_d;
  logic        frame_err_q, frame_err_d;
  logic        pix_ready_q, pix_ready_d;

  logic        accept;
  logic        do_write;
  logic [7:0]  eff_col;
  logic [7:0]  eff_row;
  logic [14:0] eff_addr;
  logic        last_beat;

  // pixReady is only high in WAIT_SOF and LOAD, so accept implies one of them.
  assign accept = bus.pixValid & pix_ready_q;

  // An SOF beat is always pixel (0,0): in WAIT_SOF that is where the counters
  // already are, in LOAD it restarts the frame from this beat.
  assign eff_col   = bus.pixSof ? 8'd0 : col_q;
  assign eff_row   = bus.pixSof ? 8'd0 : row_q;
  assign eff_addr  = bus.pixSof ? BASE : addr_q;
  assign last_beat = (eff_col == COL_MAX) && (eff_row == ROW_MAX);

  assign do_write = accept &&
                    ((state_q == LOAD) || ((state_q == WAIT_SOF) && bus.pixSof));

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    addr_d      = addr_q;
    sram_addr_d = sram_addr_q;
    sram_data_d = sram_data_q;
    wren_d      = 1'b0;
    busy_d      = busy_q;
    load_done_d = 1'b0;
    frame_err_d = frame_err_q;
    pix_ready_d = pix_ready_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = WAIT_SOF;
          frame_err_d = 1'b0;
          col_d       = 8'd0;
          row_d       = 8'd0;
          addr_d      = BASE;
          busy_d      = 1'b1;
          pix_ready_d = 1'b1;
        end
      end
      WAIT_SOF: begin
        if (accept && !bus.pixSof) begin
          frame_err_d = 1'b1;
        end
      end
      LOAD: begin
        if (accept && bus.pixSof && ((col_q != 8'd0) || (row_q != 8'd0))) begin
          frame_err_d = 1'b1;
        end
      end
      LAST_S: begin
        state_d     = DONE_S;
        load_done_d = 1'b1;
        busy_d      = 1'b0;
      end
      DONE_S: begin
        state_d = IDLE;
      end
      default: begin
        state_d     = IDLE;
        busy_d      = 1'b0;
        pix_ready_d = 1'b0;
      end
    endcase

    if (do_write) begin
      wren_d      = 1'b1;
      sram_addr_d = eff_addr;
      sram_data_d = bus.pixData;
      if (last_beat) begin
        // Park the counters rather than stepping past the end of the frame.
        state_d     = LAST_S;
        pix_ready_d = 1'b0;
        col_d       = 8'd0;
        row_d       = 8'd0;
        addr_d      = BASE;
      end else begin
        state_d = LOAD;
        addr_d  = eff_addr + 15'd1;
        if (eff_col == COL_MAX) begin
          col_d = 8'd0;
          row_d = eff_row + 8'd1;
        end else begin
          col_d = eff_col + 8'd1;
          row_d = eff_row;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state_q     <= IDLE;
      col_q       <= 8'd0;
      row_q       <= 8'd0;
      addr_q      <= BASE;
      sram_addr_q <= 15'd0;
      sram_data_q <= 8'd0;
      wren_q      <= 1'b0;
      busy_q      <= 1'b0;
      load_done_q <= 1'b0;
      frame_err_q <= 1'b0;
      pix_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      addr_q      <= addr_d;
      sram_addr_q <= sram_addr_d;
      sram_data_q <= sram_data_d;
      wren_q      <= wren_d;
      busy_q      <= busy_d;
      load_done_q <= load_done_d;
      frame_err_q <= frame_err_d;
      pix_ready_q <= pix_ready_d;
    end
  end

  assign bus.pixReady = pix_ready_q;
  assign bus.sramAddr = sram_addr_q;
  assign bus.sramData = sram_data_q;
  assign bus.wren     = wren_q;
  assign busy         = busy_q;
  assign loadDone     = load_done_q;
  assign frameErr     = frame_err_q;

endmodule

// File: tb/tb_fd_image_loader.sv
// tb/tb_fd_image_loader.sv - directed self-checking bench for fd_image_loader

module tb_fd_image_loader;

  localparam int W = 4;
  localparam int H = 2;

  logic clock  = 1'b0;
  logic nReset = 1'b0;
  logic start  = 1'b0;
  logic busy;
  logic loadDone;
  logic frameErr;

  fd_image_loader_if bus ();

  fd_image_loader #(
    .IMG_W    (W),
    .IMG_H    (H),
    .BASE_ADDR(256)
  ) dut (
    .clock   (clock),
    .nReset  (nReset),
    .start   (start),
    .bus     (bus),
    .busy    (busy),
    .loadDone(loadDone),
    .frameErr(frameErr)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [14:0] addr;
    logic [7:0]  data;
    int          cyc;
  } wr_t;

  wr_t  wr_q[$];
  int   cyc    = 0;
  int   ld_cnt = 0;
  int   ld_cyc = 0;
  logic ld_busy = 1'b0;
  int   n_cmp  = 0;
  int   n_err  = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Log every SRAM write and every loadDone pulse, sampled mid-cycle.
  always @(negedge clock) begin
    if (bus.wren === 1'b1) wr_q.push_back('{bus.sramAddr, bus.sramData, cyc});
    if (loadDone === 1'b1) begin
      ld_cnt  = ld_cnt + 1;
      ld_cyc  = cyc;
      ld_busy = busy;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  // Present one beat and hold it until the loader takes it (bounded).
  task automatic send_beat(input logic [7:0] d, input logic sof);
    logic acc;
    acc = 1'b0;
    bus.pixValid = 1'b1;
    bus.pixData  = d;
    bus.pixSof   = sof;
    for (int k = 0; k < 20 && !acc; k++) begin
      @(negedge clock);
      acc = bus.pixReady;
      tick(1);
    end
    chk("beat_accept", {31'b0, acc}, 32'd1);
    bus.pixValid = 1'b0;
    bus.pixSof   = 1'b0;
  endtask

  task automatic chk_frame(input int b, input int a0, input int d0, input int n, input int step);
    for (int i = 0; i < n; i++) begin
      if (b + i < wr_q.size()) begin
        chk("wr_addr", 32'(wr_q[b+i].addr), 32'(a0 + i));
        chk("wr_data", 32'(wr_q[b+i].data), 32'((d0 + i) & 8'hff));
        if (step > 0 && i > 0)
          chk("wr_gap", 32'(wr_q[b+i].cyc - wr_q[b+i-1].cyc), 32'(step));
      end
    end
  endtask

  task automatic chk_done(input int lb, input int ldb, input int nwr);
    chk("n_wr", 32'(wr_q.size() - lb), 32'(nwr));
    chk("ld_cnt", 32'(ld_cnt - ldb), 32'd1);
    if (wr_q.size() > 0) chk("ld_cyc", 32'(ld_cyc), 32'(wr_q[$].cyc + 1));
    chk("ld_busy", {31'b0, ld_busy}, 32'd0);
    chk("idle_busy", {31'b0, busy}, 32'd0);
    chk("idle_rdy", {31'b0, bus.pixReady}, 32'd0);
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_wren"}, {31'b0, bus.wren}, 32'd0);
    chk({pfx, "_addr"}, 32'(bus.sramAddr), 32'd0);
    chk({pfx, "_data"}, 32'(bus.sramData), 32'd0);
    chk({pfx, "_busy"}, {31'b0, busy}, 32'd0);
    chk({pfx, "_ld"}, {31'b0, loadDone}, 32'd0);
    chk({pfx, "_err"}, {31'b0, frameErr}, 32'd0);
    chk({pfx, "_rdy"}, {31'b0, bus.pixReady}, 32'd0);
  endtask

  initial begin
    int lb;
    int ldb;
    bus.pixValid = 1'b0;
    bus.pixData  = 8'h00;
    bus.pixSof   = 1'b0;

    #12;
    chk_all_zero("rst");
    @(negedge clock);
    nReset = 1'b1;
    tick(1);

    // Back-to-back frame.
    lb = wr_q.size(); ldb = ld_cnt;
    pulse_start;
    for (int i = 0; i < 8; i++) send_beat(8'(8'h10 + i), i == 0);
    tick(4);
    chk_done(lb, ldb, 8);
    chk_frame(lb, 'h100, 'h10, 8, 1);
    chk("s1_err", {31'b0, frameErr}, 32'd0);

    // pixValid toggling 1,0,1,0.
    lb = wr_q.size(); ldb = ld_cnt;
    pulse_start;
    for (int i = 0; i < 8; i++) begin
      send_beat(8'(8'h60 + i), i == 0);
      tick(1);
    end
    tick(4);
    chk_done(lb, ldb, 8);
    chk_frame(lb, 'h100, 'h60, 8, 2);

    // Two beats without SOF, then a good frame.
    lb = wr_q.size(); ldb = ld_cnt;
    pulse_start;
    send_beat(8'hAA, 1'b0);
    send_beat(8'hAB, 1'b0);
    tick(2);
    chk("s3_nowr", 32'(wr_q.size() - lb), 32'd0);
    chk("s3_err", {31'b0, frameErr}, 32'd1);
    for (int i = 0; i < 8; i++) send_beat(8'(8'h20 + i), i == 0);
    tick(4);
    chk_done(lb, ldb, 8);
    chk_frame(lb, 'h100, 'h20, 8, 1);
    chk("s3_err_sticky", {31'b0, frameErr}, 32'd1);

    // SOF reasserted at beat 5 restarts the frame.
    lb = wr_q.size(); ldb = ld_cnt;
    pulse_start;
    chk("s4_err_clr", {31'b0, frameErr}, 32'd0);
    for (int i = 0; i < 5; i++) send_beat(8'(8'h30 + i), i == 0);
    send_beat(8'h40, 1'b1);
    chk("s4_err", {31'b0, frameErr}, 32'd1);
    for (int i = 1; i < 7; i++) send_beat(8'(8'h40 + i), 1'b0);
    tick(3);
    chk("s4_no_ld", 32'(ld_cnt - ldb), 32'd0);
    send_beat(8'h47, 1'b0);
    tick(4);
    chk_done(lb, ldb, 13);
    chk_frame(lb, 'h100, 'h30, 5, 1);
    chk_frame(lb + 5, 'h100, 'h40, 8, 0);

    // Reset mid-frame, then a clean frame.
    ldb = ld_cnt;
    pulse_start;
    send_beat(8'h77, 1'b0);
    chk("s5_err_pre", {31'b0, frameErr}, 32'd1);
    send_beat(8'h50, 1'b1);
    send_beat(8'h51, 1'b0);
    send_beat(8'h52, 1'b0);
    chk("s5_wren_pre", {31'b0, bus.wren}, 32'd1);
    #2;
    nReset = 1'b0;
    #1;
    chk_all_zero("mid_rst");
    @(negedge clock);
    nReset = 1'b1;
    tick(2);
    chk("s5_rdy_idle", {31'b0, bus.pixReady}, 32'd0);
    chk("s5_no_ld", 32'(ld_cnt - ldb), 32'd0);
    lb = wr_q.size(); ldb = ld_cnt;
    pulse_start;
    for (int i = 0; i < 8; i++) send_beat(8'(8'h80 + i), i == 0);
    tick(4);
    chk_done(lb, ldb, 8);
    chk_frame(lb, 'h100, 'h80, 8, 1);
    chk("s5_err", {31'b0, frameErr}, 32'd0);

    // start during LOAD and during DONE_S is ignored.
    lb = wr_q.size(); ldb = ld_cnt;
    pulse_start;
    for (int i = 0; i < 4; i++) send_beat(8'(8'h90 + i), i == 0);
    start = 1'b1;
    send_beat(8'h94, 1'b0);
    start = 1'b0;
    for (int i = 5; i < 8; i++) send_beat(8'(8'h90 + i), 1'b0);
    tick(1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(4);
    chk_done(lb, ldb, 8);
    chk_frame(lb, 'h100, 'h90, 8, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
